dvbs2_buff_inp_gen_addr_apsk: RTL
=================================

# dvbs2_buff_inp_gen_addr_apsk

Parametrised bit-to-symbol-address generator for the DVB-S2 transmitter core, the multi-modulation successor to the BPSK-only address generator. It sits between the bit interleaver output and the constellation-mapper LUT. It groups 1 to 5 serial bits (BPSK/QPSK/8PSK/16APSK/32APSK, selected per symbol) into a LUT address, emits it with a one-cycle valid strobe, and numbers each symbol within the frame. A frame-level `resetIn` flushes any partially assembled symbol and reports the flush.

## Interface
Parameters:
- `MAX_BPS`, 5: maximum bits per symbol supported; sets address width. Legal range 1..5.
- `CNT_W`, 15: width of the symbol index counter.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `enb` input 1: clock enable. When low, all registers hold.
- `dataIn` input 1: serial bit (ufix1).
- `validIn` input 1: `dataIn` qualifier.
- `resetIn` input 1: frame restart, synchronous flush.
- `modIdx` input 3: 0=BPSK(1), 1=QPSK(2), 2=8PSK(3), 3=16APSK(4), 4=32APSK(5).
- `addrOut` output MAX_BPS: symbol LUT address, zero-extended.
- `addrValidOut` output 1: one-cycle strobe for `addrOut`/`symIdx`.
- `symIdx` output CNT_W: index of the emitted symbol since last `resetIn`.
- `flushOut` output 1: pulses when `resetIn` discards a partial symbol.
- `errOut` output 1: pulses when an illegal mode is rejected.

## Operation
- All register updates are qualified by `enb`. `reset` overrides `enb`.
- State: shift register `sr[MAX_BPS-1:0]`, bit counter `cnt` (0..MAX_BPS-1), latched `bps`, and symbol counter `sym`.
- **Symbol start:** on `validIn=1` with `cnt=0`, `modIdx` is decoded to `bps` and latched.
  - If `modIdx`>4 or the decoded bps>MAX_BPS, the mode is illegal: the bit is dropped, `errOut`=1 for the next cycle, and `cnt` stays 0.
- **Mode changes mid-symbol:** changes to `modIdx` while `cnt`≠0 are ignored until the next symbol start.
- **Bit accumulation:** on an accepted bit, `sr <= {sr[MAX_BPS-2:0], dataIn}`. The first bit of a symbol becomes the MSB of the address.
  - If `cnt` < bps-1: `cnt` increments.
  - If `cnt` = bps-1: `addrOut <= ({sr,dataIn})` masked to the low bps bits, with upper bits zero. Also `addrValidOut` <= 1, `symIdx` <= `sym`, `sym` increments (wrapping modulo 2^CNT_W), and `cnt` <= 0.
- **BPSK (bps=1):** every valid bit yields an address equal to `dataIn`, matching the legacy block.
- **`validIn`=0:** no state change. `addrValidOut` <= 0.
- **`resetIn`=1** (priority over `validIn` in the same cycle; the bit in that cycle is dropped):
  - `cnt`, `sr`, and `sym` <= 0; `addrValidOut` <= 0.
  - `flushOut` <= 1 if `cnt`≠0, else 0.
- **Output hold:** `addrOut` and `symIdx` hold their last values while `addrValidOut`=0. `flushOut` and `errOut` are single-cycle pulses.

## Timing
- **Reset values:** `addrOut`=0, `addrValidOut`=0, `symIdx`=0, `flushOut`=0, `errOut`=0, `cnt`=0, `sr`=0, `sym`=0.
- **Latency:** `addrValidOut` is asserted on the cycle after the cycle carrying the last bit of a symbol (1 register stage). Maximum throughput is 1 bit per cycle. Back-to-back BPSK bits produce one valid address per cycle.
- **Gaps:** gaps in `validIn` mid-symbol are allowed and preserve the partial state indefinitely.
- **`enb`:**
  - `enb`=0 freezes every register, including pulse outputs. A strobe present when `enb` drops stays visible until `enb` returns and the next update occurs.
  - Inputs are ignored while `enb`=0.
- **`reset` vs `resetIn`:** `reset` asserted in any cycle forces reset values on the next edge. `resetIn` only affects the datapath as described above.
- **Symbol counter wrap:** after symbol 2^CNT_W-1, `symIdx` wraps to 0 with no flag.

## Test plan
- **BPSK stream:** modIdx=0, bits 1,0,1 on consecutive cycles -> addrOut 1,0,1 with addrValidOut high on cycles 2,3,4; symIdx 0,1,2.
- **8PSK assembly:** modIdx=2, bits 1,1,0 with one idle cycle between the 2nd and 3rd bits -> a single strobe one cycle after the 3rd bit, with addrOut=5'b00110 and symIdx=0.
- **Mode latching:** start 32APSK (modIdx=4) and switch modIdx to 1 after 2 bits; send 5 bits 1,0,0,1,1 -> addrOut=19. The next symbol is QPSK: bits 1,0 -> addrOut=2.
- **Flush:** 16APSK with 2 bits in, then resetIn=1 together with validIn=1 -> flushOut pulse, no addrValidOut, and the next 4 bits 0,0,0,1 yield addrOut=1 with symIdx=0. Repeating resetIn with cnt=0 -> flushOut stays 0.
- **Illegal mode:** modIdx=6 with validIn=1 -> errOut pulse and no state change; with MAX_BPS=3, modIdx=3 -> errOut pulse.
- **Enable and reset:** drop enb mid-symbol for 4 cycles while toggling dataIn/validIn -> the result matches the run without the gap. Assert reset mid-symbol -> all outputs 0 on the next cycle, and subsequent symbols start from symIdx=0.

Source files
------------

// File: rtl/dvbs2_buff_inp_gen_addr_apsk.sv
// rtl/dvbs2_buff_inp_gen_addr_apsk.sv - serial bits to 1..5-bit constellation LUT address generator
module dvbs2_buff_inp_gen_addr_apsk #(
  parameter int MAX_BPS = 5,
  parameter int CNT_W   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enb,
  input  logic               dataIn,
  input  logic               validIn,
  input  logic               resetIn,
  input  logic [2:0]         modIdx,
  output logic [MAX_BPS-1:0] addrOut,
  output logic               addrValidOut,
  output logic [CNT_W-1:0]   symIdx,
  output logic               flushOut,
  output logic               errOut
);

  logic [MAX_BPS-1:0] sr;
  logic [2:0]         cnt;
  logic [2:0]         bps;
  logic [CNT_W-1:0]   sym;

  logic [2:0]         dec_bps;
  logic               illegal;
  logic [2:0]         cur_bps;
  logic [MAX_BPS:0]   cat;
  logic [MAX_BPS:0]   mask;
  logic [MAX_BPS:0]   masked;
  logic               last;

  // Decode the mode; a symbol start uses the fresh decode, later bits use the latched width
  always_comb begin
    dec_bps = modIdx + 3'd1;
    illegal = (modIdx > 3'd4) || (int'(modIdx) >= MAX_BPS);
    cur_bps = (cnt == 3'd0) ? dec_bps : bps;
    cat     = {sr, dataIn};
    mask    = ~({(MAX_BPS+1){1'b1}} << cur_bps);
    masked  = cat & mask;
    last    = (cnt == (cur_bps - 3'd1));
  end

  // Datapath and output registers; pulse outputs default low on every enabled cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      sr           <= '0;
      cnt          <= '0;
      bps          <= '0;
      sym          <= '0;
      addrOut      <= '0;
      addrValidOut <= 1'b0;
      symIdx       <= '0;
      flushOut     <= 1'b0;
      errOut       <= 1'b0;
    end else if (enb) begin
      addrValidOut <= 1'b0;
      flushOut     <= 1'b0;
      errOut       <= 1'b0;
      if (resetIn) begin
        flushOut <= (cnt != 3'd0);
        cnt      <= '0;
        sr       <= '0;
        sym      <= '0;
      end else if (validIn) begin
        if ((cnt == 3'd0) && illegal) begin
          errOut <= 1'b1;
        end else begin
          sr <= cat[MAX_BPS-1:0];
          if (cnt == 3'd0) begin
            bps <= dec_bps;
          end
          if (last) begin
            addrOut      <= masked[MAX_BPS-1:0];
            addrValidOut <= 1'b1;
            symIdx       <= sym;
            sym          <= sym + {{(CNT_W-1){1'b0}}, 1'b1};
            cnt          <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
      end
    end
  end

endmodule
